// File: rtl/servant_wb_loader.sv
// servant_wb_loader
//   Boot loader that receives a program image over a UART line and writes it
//   into servant_ram through a Wishbone initiator port. The CPU is held in
//   reset through o_busy until the whole image has been written.
//
//   Image format: 4-byte little-endian word count N, then N little-endian
//   data words. When LOADER_CHECKSUM_EN is defined, a 4-byte little-endian
//   trailer follows. It must equal the 32-bit wrap-around sum of the data
//   words, otherwise o_err is set.
//
//   Parameters: CLK_DIV (clocks per UART bit, >= 4), depth (memory bytes, 2^n)
//
//   Ports:
//     i_wb_clk, i_wb_rst  clock, asynchronous active-high reset
//     i_rx                UART line, 8N1, idle high, LSB first
//     o_wb_adr/dat/sel/we/cyc, i_wb_ack   Wishbone write initiator
//     o_busy              loader owns the bus (CPU held in reset)
//     o_done              image fully written (sticky)
//     o_err               sticky framing / overrun / checksum error
//
//   Loader FSM states:
//     state   | meaning
//     HDR     | collecting the 4-byte word count
//     DATA    | assembling words and writing them to memory
//     CSUM    | collecting the checksum trailer (LOADER_CHECKSUM_EN only)
//     DONE    | image loaded, bus released, further bytes ignored
module servant_wb_loader #(
  parameter int CLK_DIV = 87,
  parameter int depth   = 8192
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_rx,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [1:0] ST_CSUM = 2'd2;
  localparam logic [1:0] ST_TAIL = ST_CSUM;
`else
  localparam logic [1:0] ST_TAIL = ST_DONE;
`endif

  // ---------------- UART receiver ----------------
  logic          rx_s1, rx_s2, rx_d;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_sh;
  logic          tick;
  logic          byte_ok;
  logic          frame_err;

  assign tick      = (rx_cnt == '0);
  // Stop-bit decision is used combinationally so the word is acted on
  // in the cycle right after the stop-bit sample.
  assign byte_ok   = (rx_state == RX_STOP) && tick && rx_s2;
  assign frame_err = (rx_state == RX_STOP) && tick && !rx_s2;

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF;
          end
        end
        RX_START: begin
          if (tick) begin
            // A start bit that is high again at mid-bit was only a glitch.
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
            rx_cnt   <= FULL;
            bit_idx  <= '0;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_sh   <= {rx_s2, rx_sh[7:1]};
            bit_idx <= bit_idx + 3'd1;
            rx_cnt  <= FULL;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: begin
          if (tick) rx_state <= RX_IDLE;
          else      rx_cnt   <= rx_cnt - 1'b1;
        end
      endcase
    end
  end

  // ---------------- loader FSM / Wishbone initiator ----------------
  logic [1:0]    state;
  logic [1:0]    byte_cnt;
  logic [23:0]   byte_buf;
  logic [31:0]   words_left;
  logic [AW-1:0] adr_q;
  logic [31:0]   word;
  logic          word_ok;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   csum;
`endif

  assign word    = {rx_sh, byte_buf};
  assign word_ok = byte_ok && (byte_cnt == 2'd3) && (state != ST_DONE);

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state      <= ST_HDR;
      byte_cnt   <= '0;
      byte_buf   <= '0;
      words_left <= '0;
      adr_q      <= '0;
      o_wb_dat   <= '0;
      o_wb_cyc   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (frame_err) o_err <= 1'b1;
      if (byte_ok && state != ST_DONE) begin
        byte_cnt <= byte_cnt + 2'd1;
        byte_buf <= {rx_sh, byte_buf[23:8]};
      end
      case (state)
        ST_HDR: begin
          if (word_ok) begin
            words_left <= word;
            adr_q      <= '0;
            state      <= (word == 32'd0) ? ST_TAIL : ST_DATA;
          end
        end
        ST_DATA: begin
          if (o_wb_cyc && i_wb_ack) begin
            o_wb_cyc   <= 1'b0;
            o_wb_we    <= 1'b0;
            adr_q      <= adr_q + AW'(4);
            words_left <= words_left - 32'd1;
            if (words_left == 32'd1) state <= ST_TAIL;
          end
          // A word completing while the previous write is still open is
          // dropped; this includes the cycle in which the ack arrives.
          if (word_ok) begin
            if (o_wb_cyc) begin
              o_err <= 1'b1;
            end else begin
              o_wb_dat <= word;
              o_wb_cyc <= 1'b1;
              o_wb_we  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              csum     <= csum + word;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (word_ok) begin
            if (word != csum) o_err <= 1'b1;
            state <= ST_DONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_wb_adr = 32'(adr_q);
  assign o_wb_sel = 4'hf;
  assign o_busy   = (state != ST_DONE);
  assign o_done   = (state == ST_DONE);

endmodule

// File: tb/tb_servant_wb_loader.sv
module tb_servant_wb_loader;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        ack = 1'b0;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, busy, done, err;

  servant_wb_loader #(.CLK_DIV(CLK_DIV), .depth(DEPTH)) dut (
    .i_wb_clk (clk),
    .i_wb_rst (rst),
    .i_rx     (rx),
    .o_wb_adr (wb_adr),
    .o_wb_dat (wb_dat),
    .o_wb_sel (wb_sel),
    .o_wb_we  (wb_we),
    .o_wb_cyc (wb_cyc),
    .i_wb_ack (ack),
    .o_busy   (busy),
    .o_done   (done),
    .o_err    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          ack_hold = 1'b0;
  bit          exp_err  = 1'b0;
  int          resp_age = 0;
  logic [31:0] cap_adr, cap_dat;
  bit          stable   = 1'b1;
  bit          prev_cyc = 1'b0;
`ifdef LOADER_CHECKSUM_EN
  bit          corrupt_trailer = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Registered responder: ack one cycle after it has seen cyc, unless held.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (ack) begin
        ack = 1'b0;
        resp_age = 0;
      end else if (wb_cyc) begin
        resp_age++;
        if (resp_age >= 2 && !ack_hold) ack = 1'b1;
      end else begin
        resp_age = 0;
      end
    end
  end

  // Monitor: every acknowledged write is popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_cyc && !prev_cyc) begin
        cap_adr = wb_adr;
        cap_dat = wb_dat;
        stable  = 1'b1;
      end
      if (wb_cyc && (wb_adr !== cap_adr || wb_dat !== cap_dat || wb_we !== 1'b1 || wb_sel !== 4'hf))
        stable = 1'b0;
      if (wb_cyc && ack) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got adr %h dat %h, expected no write", wb_adr, wb_dat);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_adr", wb_adr, mon_e.adr);
          check("wr_dat", wb_dat, mon_e.dat);
          check("bus_stable", 32'(stable), 32'd1);
        end
      end
      prev_cyc = wb_cyc;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_good);
    @(negedge clk);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = stop_good;
    repeat (CLK_DIV) @(negedge clk);
    rx = 1'b1;
    if (stop_good) repeat ($urandom_range(0, 2) * CLK_DIV) @(negedge clk);
    else           repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    ack_hold = 1'b0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_err = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reference: word i of the image lands at byte address 4*i mod DEPTH.
  task automatic load(input logic [31:0] words[$]);
    logic [31:0] sum = 32'd0;
    send_word(32'(words.size()));
    foreach (words[i]) begin
      exp_q.push_back('{adr: 32'((i * 4) % DEPTH), dat: words[i]});
      sum += words[i];
      send_word(words[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    if (corrupt_trailer) begin
      send_word(sum + 32'd1);
      exp_err = 1'b1;
    end else begin
      send_word(sum);
    end
`else
    if (sum == 32'd0) ; // trailer only exists with the checksum option
`endif
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_err"}, 32'(err), 32'(exp_err));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] w1, w2, w3;
    bit          saw_cyc;
    int          t;

    // Reset / idle line
    do_reset();
    saw_cyc = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (wb_cyc) saw_cyc = 1'b1;
    end
    check("idle_cyc_seen", 32'(saw_cyc), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat", wb_dat, 32'd0);
    check("rst_sel", 32'(wb_sel), 32'hf);

    // Two known words, then trailing bytes after DONE are ignored
    q = '{32'h12345678, 32'hDEADBEEF};
    load(q);
    wait_done("two_words");
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    repeat (20) @(negedge clk);
    check("after_done_err", 32'(err), 32'd0);
    check("after_done_done", 32'(done), 32'd1);

    // N = 0
    do_reset();
    q.delete();
    load(q);
    wait_done("n_zero");

    // N = 17 wraps the 17th word to address 0
    do_reset();
    q.delete();
    for (int i = 0; i < 17; i++) q.push_back($urandom);
    load(q);
    wait_done("wrap17");

    // Framing error mid-image: byte discarded, next 4 bytes form the word
    do_reset();
    send_word(32'd1);
    send_byte(8'hA5, 1'b0);
    exp_err = 1'b1;
    check("frame_err", 32'(err), 32'd1);
    w1 = $urandom;
    exp_q.push_back('{adr: 32'd0, dat: w1});
    send_word(w1);
`ifdef LOADER_CHECKSUM_EN
    send_word(w1);
`endif
    wait_done("framing");

    // Overrun: ack withheld while another word arrives
    do_reset();
    ack_hold = 1'b1;
    send_word(32'd2);
    w1 = $urandom;
    exp_q.push_back('{adr: 32'd0, dat: w1});
    send_word(w1);
    t = 0;
    while (!wb_cyc && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("ovr_cyc_up", 32'(wb_cyc), 32'd1);
    w2 = $urandom;
    send_word(w2);
    repeat (60) @(negedge clk);
    check("ovr_err", 32'(err), 32'd1);
    check("ovr_cyc_held", 32'(wb_cyc), 32'd1);
    check("ovr_dat_held", wb_dat, w1);
    check("ovr_adr_held", wb_adr, 32'd0);
    exp_err  = 1'b1;
    ack_hold = 1'b0;
    w3 = $urandom;
    exp_q.push_back('{adr: 32'd4, dat: w3});
    send_word(w3);
`ifdef LOADER_CHECKSUM_EN
    send_word(w1 + w3);
`endif
    wait_done("overrun");

    // Reset during an open write, then a fresh image from HDR
    do_reset();
    ack_hold = 1'b1;
    send_word(32'd3);
    send_word($urandom);
    t = 0;
    while (!wb_cyc && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("midrst_cyc_up", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_cyc", 32'(wb_cyc), 32'd0);
    check("midrst_we", 32'(wb_we), 32'd0);
    check("midrst_adr", wb_adr, 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    do_reset();
    q = '{$urandom};
    load(q);
    wait_done("after_midrst");

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    q = '{32'h00000005};
    load(q);
    wait_done("csum_good");
    do_reset();
    corrupt_trailer = 1'b1;
    load(q);
    wait_done("csum_bad");
    corrupt_trailer = 1'b0;
`endif

    // Randomized images
    for (int r = 0; r < 3; r++) begin
      do_reset();
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) q.push_back($urandom);
      load(q);
      wait_done("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
